// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - round-robin arbiter sharing one memory between a scalar and a vector requester
//
// Purpose: accepts one access at a time from either requester, drives the owner's
// memory port for LAT cycles, captures read data and acknowledges with a one-cycle pulse.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   s_req/s_we/s_addr/s_wdata  scalar request (held until s_ack)
//   s_ack/s_rdata            scalar completion pulse and read data
//   v_req/v_we/v_addr/v_wdata  vector request (256-bit data)
//   v_ack/v_rdata            vector completion pulse and read data
//   scalar_data_address, ScalarMemRead, ScalarMemWrite, write_scalar_data  scalar memory port
//   vector_data_address, VectorMemRead, VectorMemWrite, write_vector_data  vector memory port
//   scalar_data_read, vector_data  memory read buses
//   busy                     high whenever the FSM is not idle
module memory_arbiter #(
   parameter int N   = 24,
   parameter int LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_req,
   input  logic         s_we,
   input  logic [N-1:0] s_addr,
   input  logic [N-1:0] s_wdata,
   output logic         s_ack,
   output logic [N-1:0] s_rdata,
   input  logic         v_req,
   input  logic         v_we,
   input  logic [N-1:0] v_addr,
   input  logic [255:0] v_wdata,
   output logic         v_ack,
   output logic [255:0] v_rdata,
   output logic [N-1:0] scalar_data_address,
   output logic         ScalarMemRead,
   output logic         ScalarMemWrite,
   output logic [N-1:0] write_scalar_data,
   output logic [N-1:0] vector_data_address,
   output logic         VectorMemRead,
   output logic         VectorMemWrite,
   output logic [255:0] write_vector_data,
   input  logic [N-1:0] scalar_data_read,
   input  logic [255:0] vector_data,
   output logic         busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam bit         LAT_ONE  = (LAT == 1);
   localparam logic [1:0] WAIT_CYC = 2'(LAT - 1);

   state_t         state, state_nxt;
   logic [1:0]     cnt;
   logic           own_vec;     // 1: vector owns the current transaction
   logic           last_vec;    // 1: vector was granted last
   logic           we_q;
   logic [N-1:0]   addr_q;
   logic [N-1:0]   s_wdata_q;
   logic [255:0]   v_wdata_q;

   logic           take;        // accept a request this cycle
   logic           grant_vec;   // winner of this cycle's arbitration
   logic           cap;         // this is the final ACCESS/WAIT cycle
   logic           drive;
   logic           en;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      grant_vec = 1'b0;
      cap       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (s_req || v_req) begin
               take      = 1'b1;
               // Vector wins if it is alone, or on a tie when scalar had the last grant.
               grant_vec = v_req && (!s_req || !last_vec);
               state_nxt = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (LAT_ONE) begin
               cap       = 1'b1;
               state_nxt = ST_DONE;
            end else begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt == 2'd1) begin
               cap       = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= 2'd0;
         own_vec   <= 1'b0;
         last_vec  <= 1'b1;
         we_q      <= 1'b0;
         addr_q    <= '0;
         s_wdata_q <= '0;
         v_wdata_q <= '0;
         s_rdata   <= '0;
         v_rdata   <= '0;
      end else begin
         if (take) begin
            own_vec  <= grant_vec;
            last_vec <= grant_vec;
            if (grant_vec) begin
               we_q      <= v_we;
               addr_q    <= v_addr;
               v_wdata_q <= v_wdata;
            end else begin
               we_q      <= s_we;
               addr_q    <= s_addr;
               s_wdata_q <= s_wdata;
            end
         end
         if (state == ST_ACCESS && !LAT_ONE) begin
            cnt <= WAIT_CYC;
         end else if (state == ST_WAIT) begin
            cnt <= cnt - 2'd1;
         end
         if (cap && !we_q) begin
            if (own_vec) begin
               v_rdata <= vector_data;
            end else begin
               s_rdata <= scalar_data_read;
            end
         end
      end
   end

   // Address/data stay on the bus for the whole access window; enables pulse only in ACCESS.
   assign drive = (state == ST_ACCESS) || (state == ST_WAIT);
   assign en    = (state == ST_ACCESS);

   assign scalar_data_address = (drive && !own_vec) ? addr_q    : '0;
   assign write_scalar_data   = (drive && !own_vec) ? s_wdata_q : '0;
   assign ScalarMemRead       = en && !own_vec && !we_q;
   assign ScalarMemWrite      = en && !own_vec &&  we_q;

   assign vector_data_address = (drive && own_vec) ? addr_q    : '0;
   assign write_vector_data   = (drive && own_vec) ? v_wdata_q : '0;
   assign VectorMemRead       = en && own_vec && !we_q;
   assign VectorMemWrite      = en && own_vec &&  we_q;

   assign s_ack = (state == ST_DONE) && !own_vec;
   assign v_ack = (state == ST_DONE) &&  own_vec;
   assign busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - directed self-checking bench for memory_arbiter at LAT=1 and LAT=3
module tb_memory_arbiter;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_req, s_we, v_req, v_we;
   logic [23:0]   s_addr, s_wdata, v_addr, scalar_data_read;
   logic [255:0]  v_wdata, vector_data;

   logic          s_ack1, v_ack1, smr1, smw1, vmr1, vmw1, busy1;
   logic [23:0]   s_rdata1, sa1, wsd1, va1;
   logic [255:0]  v_rdata1, wvd1;

   logic          s_ack3, v_ack3, smr3, smw3, vmr3, vmw3, busy3;
   logic [23:0]   s_rdata3, sa3, wsd3, va3;
   logic [255:0]  v_rdata3, wvd3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   memory_arbiter #(.N(24), .LAT(1)) u1 (
      .clk(clk), .rst(rst),
      .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_ack(s_ack1), .s_rdata(s_rdata1),
      .v_req(v_req), .v_we(v_we), .v_addr(v_addr), .v_wdata(v_wdata),
      .v_ack(v_ack1), .v_rdata(v_rdata1),
      .scalar_data_address(sa1), .ScalarMemRead(smr1), .ScalarMemWrite(smw1),
      .write_scalar_data(wsd1),
      .vector_data_address(va1), .VectorMemRead(vmr1), .VectorMemWrite(vmw1),
      .write_vector_data(wvd1),
      .scalar_data_read(scalar_data_read), .vector_data(vector_data),
      .busy(busy1)
   );

   memory_arbiter #(.N(24), .LAT(3)) u3 (
      .clk(clk), .rst(rst),
      .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_ack(s_ack3), .s_rdata(s_rdata3),
      .v_req(v_req), .v_we(v_we), .v_addr(v_addr), .v_wdata(v_wdata),
      .v_ack(v_ack3), .v_rdata(v_rdata3),
      .scalar_data_address(sa3), .ScalarMemRead(smr3), .ScalarMemWrite(smw3),
      .write_scalar_data(wsd3),
      .vector_data_address(va3), .VectorMemRead(vmr3), .VectorMemWrite(vmw3),
      .write_vector_data(wvd3),
      .scalar_data_read(scalar_data_read), .vector_data(vector_data),
      .busy(busy3)
   );

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic do_reset();
      s_req = 1'b0;
      v_req = 1'b0;
      rst   = 1'b0;
      cyc();
      cyc();
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      s_req = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
      v_req = 1'b0; v_we = 1'b0; v_addr = '0; v_wdata = '0;
      scalar_data_read = '0; vector_data = '0;
      cyc();
      cyc();

      // reset state
      chk("rst_busy1", busy1, 0);
      chk("rst_busy3", busy3, 0);
      chk("rst_acks", {s_ack1, v_ack1, s_ack3, v_ack3}, 0);
      chk("rst_en", {smr1, smw1, vmr1, vmw1, smr3, smw3, vmr3, vmw3}, 0);
      chk("rst_srdata", s_rdata1, 0);
      chk("rst_vrdata", v_rdata1, 0);
      chk("rst_addr", {sa1, va1}, 0);

      // LAT=1 scalar read
      do_reset();
      s_req = 1'b1; s_we = 1'b0; s_addr = 24'h2; scalar_data_read = 24'h00ABCD;
      cyc();
      chk("rd_smr", smr1, 1);
      chk("rd_addr", sa1, 24'h2);
      chk("rd_busy", busy1, 1);
      chk("rd_ack_early", s_ack1, 0);
      cyc();
      chk("rd_ack", s_ack1, 1);
      chk("rd_data", s_rdata1, 24'h00ABCD);
      chk("rd_smr_done", smr1, 0);
      chk("rd_addr_done", sa1, 0);
      s_req = 1'b0;
      cyc();
      chk("rd_ack_off", s_ack1, 0);
      chk("rd_idle", busy1, 0);
      chk("rd_hold", s_rdata1, 24'h00ABCD);

      // tie after reset, both requests held
      do_reset();
      s_req = 1'b1; v_req = 1'b1; s_we = 1'b0; v_we = 1'b0;
      s_addr = 24'h10; v_addr = 24'h20;
      scalar_data_read = 24'h000111; vector_data = 256'hBEEF;
      cyc();
      chk("tie_smr", smr1, 1);
      chk("tie_vmr", vmr1, 0);
      chk("tie_sa", sa1, 24'h10);
      cyc();
      chk("tie_sack", s_ack1, 1);
      chk("tie_vack0", v_ack1, 0);
      chk("tie_sdata", s_rdata1, 24'h000111);
      cyc();
      chk("tie_gap", busy1, 0);
      cyc();
      chk("tie2_vmr", vmr1, 1);
      chk("tie2_smr", smr1, 0);
      chk("tie2_va", va1, 24'h20);
      cyc();
      chk("tie2_vack", v_ack1, 1);
      chk("tie2_sack0", s_ack1, 0);
      chk("tie2_vdata", v_rdata1, 256'hBEEF);
      v_req = 1'b0;
      cyc();
      chk("tie3_gap", busy1, 0);
      cyc();
      chk("tie3_smr", smr1, 1);
      cyc();
      chk("tie3_sack", s_ack1, 1);
      s_req = 1'b0;

      // vector write
      do_reset();
      vector_data = 256'hDEAD;
      v_req = 1'b1; v_we = 1'b1; v_addr = 24'h40; v_wdata = 256'h1;
      cyc();
      chk("vw_vmw", vmw1, 1);
      chk("vw_vmr", vmr1, 0);
      chk("vw_wdata", wvd1, 256'h1);
      chk("vw_addr", va1, 24'h40);
      chk("vw_scalar_en", {smr1, smw1}, 0);
      cyc();
      chk("vw_ack", v_ack1, 1);
      chk("vw_vmw_done", vmw1, 0);
      chk("vw_wdata_done", wvd1, 0);
      chk("vw_rdata", v_rdata1, 0);
      v_req = 1'b0;
      cyc();
      chk("vw_ack_off", v_ack1, 0);
      chk("vw_rdata_hold", v_rdata1, 0);

      // LAT=3 scalar read
      do_reset();
      s_req = 1'b1; s_we = 1'b0; s_addr = 24'h5; scalar_data_read = 24'h000111;
      cyc();
      chk("l3_smr", smr3, 1);
      chk("l3_busy", busy3, 1);
      cyc();
      chk("l3_w1_smr", smr3, 0);
      chk("l3_w1_addr", sa3, 24'h5);
      chk("l3_w1_ack", s_ack3, 0);
      scalar_data_read = 24'h000222;
      cyc();
      chk("l3_w2_ack", s_ack3, 0);
      chk("l3_w2_addr", sa3, 24'h5);
      scalar_data_read = 24'h000333;
      cyc();
      chk("l3_ack", s_ack3, 1);
      chk("l3_data", s_rdata3, 24'h000333);
      chk("l3_addr_done", sa3, 0);
      s_req = 1'b0;
      scalar_data_read = 24'h000444;
      cyc();
      chk("l3_ack_off", s_ack3, 0);
      chk("l3_hold", s_rdata3, 24'h000333);
      chk("l3_idle", busy3, 0);

      // request dropped during ACCESS
      do_reset();
      s_req = 1'b1; s_we = 1'b1; s_addr = 24'h7; s_wdata = 24'h123456;
      cyc();
      chk("drop_busy_acc", busy1, 1);
      chk("drop_smw", smw1, 1);
      chk("drop_wdata", wsd1, 24'h123456);
      s_req = 1'b0;
      cyc();
      chk("drop_ack", s_ack1, 1);
      chk("drop_busy_done", busy1, 1);
      chk("drop_rdata", s_rdata1, 0);
      cyc();
      chk("drop_ack_off", s_ack1, 0);
      chk("drop_idle", busy1, 0);
      cyc();
      chk("drop_idle2", busy1, 0);

      // reset during WAIT (LAT=3)
      do_reset();
      s_req = 1'b1; s_we = 1'b0; s_addr = 24'h9; scalar_data_read = 24'h000555;
      cyc();
      cyc();
      chk("rw_busy", busy3, 1);
      chk("rw_addr", sa3, 24'h9);
      rst = 1'b0;
      s_req = 1'b0;
      #1;
      chk("rw_async_busy", busy3, 0);
      chk("rw_async_addr", sa3, 0);
      chk("rw_async_en", {smr3, smw3}, 0);
      cyc();
      chk("rw_noack1", s_ack3, 0);
      cyc();
      chk("rw_noack2", s_ack3, 0);
      chk("rw_rdata", s_rdata3, 0);
      rst = 1'b1;
      cyc();
      chk("rw_idle", busy3, 0);
      s_req = 1'b1; s_we = 1'b1; s_addr = 24'hA; s_wdata = 24'h000777;
      cyc();
      chk("rw2_smw", smw3, 1);
      chk("rw2_wdata", wsd3, 24'h000777);
      cyc();
      cyc();
      chk("rw2_ack_early", s_ack3, 0);
      cyc();
      chk("rw2_ack", s_ack3, 1);
      s_req = 1'b0;
      cyc();
      chk("rw2_idle", busy3, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
